mem_port_arbiter: RTL and testbench

//  Shares one synchronous single-port word memory between the instruction-fetch

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_starve_guard.sv | 38 +++
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 tb/tb_mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 30;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned BE_W       = 4;

    // Which requester owns the read that is currently in flight in the memory
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arb_starve_guard.sv
// Counts consecutive cycles in which a fetch request was denied and raises
// force_if once the count reaches STARVE_MAX, so fetch wins the next arbitration.
module mem_arb_starve_guard #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic if_gnt,
    output logic force_if
);

    // +2 keeps the counter at least one bit wide even for STARVE_MAX == 0
    localparam int unsigned CW = $clog2(STARVE_MAX + 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!if_req || if_gnt) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(STARVE_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_if = if_req && (cnt_q == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous word memory between fetch and load/store.
// Optional perf counters are built when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = 4
`ifdef MEM_ARB_STATS_EN
    ,
    parameter int unsigned CNT_W      = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [BE_W-1:0]   d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic [BE_W-1:0]   mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_if_stall,
    output logic [CNT_W-1:0]  stat_d_access
`endif
);

    logic   force_if;
    owner_e owner_q;
    owner_e owner_d;

    mem_arb_starve_guard #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_guard (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_gnt   (if_gnt),
        .force_if (force_if)
    );

    // Data wins unless fetch has starved long enough; nothing is granted in reset
    assign d_gnt  = !rst && d_req && !force_if;
    assign if_gnt = !rst && if_req && !d_gnt;

    assign mem_en   = if_gnt || d_gnt;
    assign mem_we   = (d_gnt && d_we) ? d_be : '0;
    assign mem_addr = d_gnt ? d_addr : if_addr;
    assign mem_din  = d_wdata;

    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (d_gnt && !d_we) begin
            owner_d = OWN_D;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Read data is steered to whichever port issued last cycle's read
    assign if_rvalid = (owner_q == OWN_IF);
    assign d_rvalid  = (owner_q == OWN_D);
    assign if_rdata  = if_rvalid ? mem_dout : '0;
    assign d_rdata   = d_rvalid ? mem_dout : '0;

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_if_stall <= '0;
            stat_d_access <= '0;
        end else begin
            if (if_req && !if_gnt && (stat_if_stall != '1)) begin
                stat_if_stall <= stat_if_stall + CNT_W'(1);
            end
            if (d_gnt && (stat_d_access != '1)) begin
                stat_d_access <= stat_d_access + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised + directed bench for mem_port_arbiter with a behavioural reference
// model and a simple memory; stats checks are built when MEM_ARB_STATS_EN is defined.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W     = 30;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned CNT_W      = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
`ifdef MEM_ARB_STATS_EN
    logic [CNT_W-1:0]  stat_if_stall;
    logic [CNT_W-1:0]  stat_d_access;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
`ifdef MEM_ARB_STATS_EN
        ,
        .CNT_W      (CNT_W)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_if_stall (stat_if_stall),
        .stat_d_access (stat_d_access)
`endif
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 32'h20) ? 32'h0 : (32'hC0DE_0000 | 32'(i));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Synchronous single-port memory, read-before-write, 256 words
    logic [31:0] mem [256];
    logic        mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_din[8*b +: 8];
            mem_dout <= mem[mem_addr[7:0]];
        end
    end

    // Reference model: arbitration rules, shadow memory, pending read, counters
    logic [31:0] ref_mem [256];
    int          denied = 0;
    bit          pend_if = 0, pend_d = 0;
    logic [31:0] pend_data = '0;
    int          m_stall = 0, m_acc = 0;

    initial for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    always @(negedge clk) begin : model
        bit          frc, e_d, e_if;
        logic [29:0] ea;
        if (rst) begin
            chk("rst_if_gnt", if_gnt, 0);
            chk("rst_d_gnt", d_gnt, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_if_rvalid", if_rvalid, 0);
            chk("rst_d_rvalid", d_rvalid, 0);
            chk("rst_if_rdata", if_rdata, 0);
            chk("rst_d_rdata", d_rdata, 0);
`ifdef MEM_ARB_STATS_EN
            chk("rst_stat_stall", stat_if_stall, 0);
            chk("rst_stat_acc", stat_d_access, 0);
`endif
            pend_if = 0; pend_d = 0; denied = 0; m_stall = 0; m_acc = 0;
        end else begin
            chk("if_rvalid", if_rvalid, pend_if);
            chk("d_rvalid", d_rvalid, pend_d);
            chk("if_rdata", if_rdata, pend_if ? pend_data : 32'h0);
            chk("d_rdata", d_rdata, pend_d ? pend_data : 32'h0);
`ifdef MEM_ARB_STATS_EN
            chk("stat_if_stall", stat_if_stall, m_stall);
            chk("stat_d_access", stat_d_access, m_acc);
`endif
            frc  = if_req && (denied >= STARVE_MAX);
            e_d  = d_req && !frc;
            e_if = if_req && !e_d;
            ea   = e_d ? d_addr : if_addr;
            chk("if_gnt", if_gnt, e_if);
            chk("d_gnt", d_gnt, e_d);
            chk("mem_en", mem_en, e_if || e_d);
            chk("mem_we", mem_we, (e_d && d_we) ? d_be : 4'h0);
            chk("mem_addr", mem_addr, ea);
            chk("mem_din", mem_din, d_wdata);
            pend_if   = e_if;
            pend_d    = e_d && !d_we;
            pend_data = ref_mem[ea[7:0]];
            if (e_d && d_we)
                for (int b = 0; b < 4; b++)
                    if (d_be[b]) ref_mem[ea[7:0]][8*b +: 8] = d_wdata[8*b +: 8];
            if (if_req && !e_if) begin
                if (denied < STARVE_MAX) denied++;
                if (m_stall < 65535) m_stall++;
            end else begin
                denied = 0;
            end
            if (e_d && m_acc < 65535) m_acc++;
        end
    end

    task automatic step(input bit ir, input logic [29:0] ia, input bit dr, input bit dw,
                        input logic [3:0] be, input logic [29:0] da, input logic [31:0] wd);
        @(posedge clk); #1;
        if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_be = be; d_addr = da; d_wdata = wd;
        @(negedge clk); #1;
    endtask

    task automatic idle();
        step(0, 30'h0, 0, 0, 4'h0, 30'h0, 32'h0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin : stim
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
        #1 rst = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("init_if_rvalid", if_rvalid, 0);
        chk("init_d_rdata", d_rdata, 0);
        @(posedge clk); #1 rst = 0;
        idle();

        // fetch-only stream
        for (int k = 0; k < 4; k++) begin
            step(1, 30'(32'h10 + k), 0, 0, 4'h0, 30'h0, 32'h0);
            chk("s1_if_gnt", if_gnt, 1);
            if (k > 0) chk("s1_if_rdata", if_rdata, init_word(32'h10 + k - 1));
            chk("s1_d_rvalid", d_rvalid, 0);
        end
        idle();
        chk("s1_if_rdata_last", if_rdata, 32'hC0DE_0013);

        // simultaneous fetch and data read: data wins
        step(1, 30'h50, 1, 0, 4'h0, 30'h40, 32'h0);
        chk("s2_d_gnt", d_gnt, 1);
        chk("s2_if_gnt", if_gnt, 0);
        idle();
        chk("s2_d_rvalid", d_rvalid, 1);
        chk("s2_d_rdata", d_rdata, 32'hC0DE_0040);
        chk("s2_if_rdata", if_rdata, 0);

        // partial write, then read back
        step(0, 30'h0, 1, 1, 4'b0011, 30'h20, 32'hAABB_CCDD);
        chk("s4_d_gnt", d_gnt, 1);
        chk("s4_mem_we", mem_we, 4'b0011);
        idle();
        chk("s4_no_d_rvalid", d_rvalid, 0);
        chk("s4_no_if_rvalid", if_rvalid, 0);
        step(0, 30'h0, 1, 0, 4'h0, 30'h20, 32'h0);
        idle();
        chk("s4_readback", d_rdata, 32'h0000_CCDD);

        // reset in the cycle after a read grant, with the fetch counter part-way up
        repeat (3) step(1, 30'h51, 1, 0, 4'h0, 30'h41, 32'h0);
        @(posedge clk); #1 rst = 1;
        @(negedge clk); #1;
        chk("s5_d_rvalid", d_rvalid, 0);
        chk("s5_d_rdata", d_rdata, 0);
        chk("s5_if_gnt", if_gnt, 0);
        chk("s5_d_gnt", d_gnt, 0);
        chk("s5_mem_en", mem_en, 0);
        @(posedge clk); #1 rst = 0; if_req = 0; d_req = 0;
        @(negedge clk); #1;

        // starvation guard: fetch forced on the 5th and 10th contended cycles
        for (int k = 0; k < 10; k++) begin
            step(1, 30'h52, 1, 0, 4'h0, 30'h42, 32'h0);
            chk("s3_if_gnt", if_gnt, (k == 4 || k == 9));
            chk("s3_d_gnt", d_gnt, !(k == 4 || k == 9));
        end
        idle();
`ifdef MEM_ARB_STATS_EN
        chk("s6_stat_if_stall", stat_if_stall, 8);
        chk("s6_stat_d_access", stat_d_access, 8);
`endif

        // randomised traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                @(posedge clk); #1 rst = 1;
                repeat (2) @(negedge clk);
                @(posedge clk); #1 rst = 0; if_req = 0; d_req = 0;
                @(negedge clk); #1;
            end
            step($urandom_range(0, 3) != 0, 30'($urandom_range(0, 255)),
                 $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 30'($urandom_range(0, 255)), $urandom);
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
